// File: rtl/camera_ctrl_param.sv
// Pixel-array capture controller: exposure register with saturating adjust, and an
// erase/expose/row-readout sequencer with optional multi-frame burst per Init request.
module camera_ctrl_param #(
  parameter int ROWS       = 2,
  parameter int ADC_CYCLES = 2,
  parameter int EXP_W      = 5,
  parameter int EXP_MIN    = 2,
  parameter int EXP_MAX    = 30,
  parameter int EXP_RST    = 15,
  parameter int BURST_W    = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Init,
  input  logic               Exp_increase,
  input  logic               Exp_decrease,
  input  logic               Mode,
  input  logic [BURST_W-1:0] Burst_len,
  output logic [ROWS-1:0]    NRE,
  output logic               ADC,
  output logic               Expose,
  output logic               Erase,
  output logic               Busy,
  output logic               Done,
  output logic [EXP_W-1:0]   EX_time
);

  localparam int WIN   = ADC_CYCLES + 2;
  localparam int SUB_W = $clog2(WIN);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [EXP_W-1:0]   E_MIN     = EXP_W'(EXP_MIN);
  localparam logic [EXP_W-1:0]   E_MAX     = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0]   E_RST     = EXP_W'(EXP_RST);
  localparam logic [SUB_W-1:0]   SUB_LAST  = SUB_W'(WIN - 1);
  localparam logic [SUB_W-1:0]   SUB_ADC   = SUB_W'(ADC_CYCLES);
  localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [BURST_W-1:0] ONE_FRAME = BURST_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_EXPOSE, S_READ, S_ERASE} state_t;

  state_t             r_state;
  logic [EXP_W-1:0]   r_exp;     // exposure latched at Init, reused for every burst frame
  logic [EXP_W-1:0]   r_cnt;
  logic [BURST_W-1:0] r_frames;
  logic [ROW_W-1:0]   r_row;
  logic [SUB_W-1:0]   r_sub;

  function automatic logic [ROWS-1:0] row_sel_n(input logic [ROW_W-1:0] row);
    return ~(ROWS'(1) << row);
  endfunction

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state  <= S_IDLE;
      NRE      <= '1;
      ADC      <= 1'b0;
      Expose   <= 1'b0;
      Erase    <= 1'b1;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      EX_time  <= E_RST;
      r_exp    <= '0;
      r_cnt    <= '0;
      r_frames <= '0;
      r_row    <= '0;
      r_sub    <= '0;
    end else begin
      // NOTE: non-blocking default; a later assignment in this block wins, so Done is a one-cycle pulse.
      Done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Exp_increase && !Exp_decrease && EX_time < E_MAX)
            EX_time <= EX_time + 1'b1;
          else if (Exp_decrease && !Exp_increase && EX_time > E_MIN)
            EX_time <= EX_time - 1'b1;
          if (Init) begin
            r_exp    <= EX_time;
            r_cnt    <= EX_time - 1'b1;
            r_frames <= (Mode && Burst_len != '0) ? Burst_len : ONE_FRAME;
            r_state  <= S_EXPOSE;
            Expose   <= 1'b1;
            Erase    <= 1'b0;
            Busy     <= 1'b1;
          end
        end
        S_EXPOSE: begin
          if (r_cnt == '0) begin
            r_state <= S_READ;
            Expose  <= 1'b0;
            NRE     <= row_sel_n('0);
            r_row   <= '0;
            r_sub   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_READ: begin
          if (r_sub == SUB_LAST) begin
            ADC <= 1'b0;
            if (r_row != ROW_LAST) begin
              r_row <= r_row + 1'b1;
              NRE   <= row_sel_n(r_row + 1'b1);
              r_sub <= '0;
            end else begin
              NRE   <= '1;
              Erase <= 1'b1;
              if (r_frames > ONE_FRAME) begin
                r_state  <= S_ERASE;
                r_frames <= r_frames - 1'b1;
              end else begin
                r_state <= S_IDLE;
                Busy    <= 1'b0;
                Done    <= 1'b1;
              end
            end
          end else begin
            r_sub <= r_sub + 1'b1;
            ADC   <= (r_sub < SUB_ADC);
          end
        end
        S_ERASE: begin
          r_state <= S_EXPOSE;
          Erase   <= 1'b0;
          Expose  <= 1'b1;
          r_cnt   <= r_exp - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_ctrl_param.sv
// Randomised bench for camera_ctrl_param; expected waveforms come from the timing
// equations (frame length, row windows, burst spacing) evaluated per cycle offset.
module tb_camera_ctrl_param;

  localparam int ROWS = 2, AC = 2, EXP_W = 5, EXP_MIN = 2, EXP_MAX = 30, EXP_RST = 15, BURST_W = 4;
  localparam int R  = AC + 2;
  localparam int OW = ROWS + 5 + EXP_W;

  logic               Clk = 1'b0;
  logic               Reset = 1'b0;
  logic               Init = 1'b0, Exp_increase = 1'b0, Exp_decrease = 1'b0, Mode = 1'b0;
  logic [BURST_W-1:0] Burst_len = '0;
  logic [ROWS-1:0]    NRE;
  logic               ADC, Expose, Erase, Busy, Done;
  logic [EXP_W-1:0]   EX_time;

  int n_pass = 0, n_total = 0;
  int ex_model = EXP_RST;
  logic [OW-1:0] got, exp_v;

  camera_ctrl_param #(
    .ROWS(ROWS), .ADC_CYCLES(AC), .EXP_W(EXP_W), .EXP_MIN(EXP_MIN),
    .EXP_MAX(EXP_MAX), .EXP_RST(EXP_RST), .BURST_W(BURST_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Init(Init), .Exp_increase(Exp_increase),
    .Exp_decrease(Exp_decrease), .Mode(Mode), .Burst_len(Burst_len),
    .NRE(NRE), .ADC(ADC), .Expose(Expose), .Erase(Erase), .Busy(Busy),
    .Done(Done), .EX_time(EX_time)
  );

  always #5 Clk = ~Clk;

  assign got = {NRE, ADC, Expose, Erase, Busy, Done, EX_time};

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Expected outputs at cycle offset t after the Init-sampling edge, for exposure e and n frames.
  function automatic logic [OW-1:0] model(int t, int e, int n, int ex);
    int f, tot, u, k, s;
    logic [ROWS-1:0] nre;
    logic adc, expo, era, busy, done;
    f = e + ROWS * R;
    tot = n * f + n - 1;
    nre = '1; adc = 1'b0; expo = 1'b0; era = 1'b1; busy = 1'b0; done = 1'b0;
    if (t >= 0 && t < tot) begin
      busy = 1'b1;
      era  = 1'b0;
      u = t % (f + 1);
      if (u == f) era = 1'b1;
      else if (u < e) expo = 1'b1;
      else begin
        k = (u - e) / R;
        s = (u - e) % R;
        nre[k] = 1'b0;
        adc = (s >= 1 && s <= AC);
      end
    end else if (t == tot) begin
      done = 1'b1;
    end
    return {nre, adc, expo, era, busy, done, EXP_W'(ex)};
  endfunction

  function automatic int frame_total(int e, int n);
    return n * (e + ROWS * R) + n - 1;
  endfunction

  task automatic do_reset();
    Reset = 1'b0; Init = 1'b0; Exp_increase = 1'b0; Exp_decrease = 1'b0; Mode = 1'b0; Burst_len = '0;
    tick();
    Reset = 1'b1;
    ex_model = EXP_RST;
  endtask

  // Drive one button cycle in IDLE and update the saturating exposure model.
  task automatic press(logic inc, logic dec);
    Exp_increase = inc;
    Exp_decrease = dec;
    tick();
    if (inc && !dec && ex_model < EXP_MAX) ex_model++;
    else if (dec && !inc && ex_model > EXP_MIN) ex_model--;
    Exp_increase = 1'b0;
    Exp_decrease = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      n_total++;
      exp_v = {{ROWS{1'b1}}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, EXP_W'(EXP_RST)};
      if (got !== exp_v) $display("FAIL reset cyc=%0d got=%h expected=%h", i, got, exp_v);
      else n_pass++;
      if (i == 1) Reset = 1'b1;
      tick();
    end
    ex_model = EXP_RST;
  endtask

  task automatic test_exposure();
    for (int i = 0; i < 60; i++) begin
      if (i < 20) press(1'b1, 1'b0);
      else if (i < 55) press(1'b0, 1'b1);
      else press(1'b1, 1'b1);
      n_total++;
      if (EX_time !== EXP_W'(ex_model)) $display("FAIL exposure_adj i=%0d got=%0d expected=%0d", i, EX_time, ex_model);
      else n_pass++;
      if (i == 19) begin
        n_total++;
        if (EX_time !== EXP_W'(EXP_MAX)) $display("FAIL exposure_max got=%0d expected=%0d", EX_time, EXP_MAX);
        else n_pass++;
      end
    end
    n_total++;
    if (EX_time !== EXP_W'(EXP_MIN)) $display("FAIL exposure_min got=%0d expected=%0d", EX_time, EXP_MIN);
    else n_pass++;
  endtask

  task automatic test_single();
    int tot;
    do_reset();
    Mode = 1'b0;
    tot = frame_total(ex_model, 1);
    Init = 1'b1;
    tick();
    Init = 1'b0;
    for (int t = 0; t <= tot + 2; t++) begin
      if (t > 0) tick();
      exp_v = model(t, ex_model, 1, ex_model);
      n_total++;
      if (got !== exp_v) $display("FAIL single t=%0d got=%h expected=%h", t, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_burst(int bl, string name);
    int n, tot;
    do_reset();
    for (int i = 0; i < 13; i++) press(1'b0, 1'b1);
    Mode = 1'b1;
    Burst_len = BURST_W'(bl);
    n = (bl == 0) ? 1 : bl;
    tot = frame_total(ex_model, n);
    Init = 1'b1;
    tick();
    Init = 1'b0;
    Mode = 1'b0;
    Burst_len = '0;
    for (int t = 0; t <= tot + 2; t++) begin
      if (t > 0) tick();
      exp_v = model(t, ex_model, n, ex_model);
      n_total++;
      if (got !== exp_v) $display("FAIL %s t=%0d got=%h expected=%h", name, t, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_ignore_busy();
    int e, tot;
    do_reset();
    for (int i = 0; i < 5; i++) press(1'b0, 1'b1);
    e = ex_model;
    tot = frame_total(e, 1);
    Init = 1'b1;
    tick();
    Init = 1'b0;
    for (int t = 0; t <= tot + 3; t++) begin
      if (t > 0) tick();
      exp_v = model(t, e, 1, ex_model);
      n_total++;
      if (got !== exp_v) $display("FAIL ignore_busy t=%0d got=%h expected=%h", t, got, exp_v);
      else n_pass++;
      if (t + 1 >= e && t + 1 < tot) begin
        Init = t[0]; Exp_increase = 1'b1; Mode = 1'b1; Burst_len = BURST_W'($urandom);
      end else begin
        Init = 1'b0; Exp_increase = 1'b0; Mode = 1'b0; Burst_len = '0;
      end
    end
  endtask

  task automatic test_back_to_back();
    int e, tot;
    do_reset();
    e = ex_model;
    tot = frame_total(e, 1);
    Init = 1'b1;
    tick();
    for (int t = 0; t <= 2 * tot + 2; t++) begin
      if (t > 0) tick();
      exp_v = (t <= tot) ? model(t, e, 1, ex_model) : model(t - tot - 1, e, 1, ex_model);
      n_total++;
      if (got !== exp_v) $display("FAIL back_to_back t=%0d got=%h expected=%h", t, got, exp_v);
      else n_pass++;
      Init = (t + 1 <= tot + 1);
    end
    Init = 1'b0;
  endtask

  task automatic test_abort();
    int e, cut;
    do_reset();
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
    e = ex_model;
    cut = e + R + 1;
    Init = 1'b1;
    tick();
    Init = 1'b0;
    for (int t = 0; t <= cut; t++) begin
      if (t > 0) tick();
      exp_v = model(t, e, 1, ex_model);
      n_total++;
      if (got !== exp_v) $display("FAIL abort_pre t=%0d got=%h expected=%h", t, got, exp_v);
      else n_pass++;
    end
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    ex_model = EXP_RST;
    for (int i = 0; i < 2 * R + 4; i++) begin
      if (i > 0) tick();
      exp_v = {{ROWS{1'b1}}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, EXP_W'(EXP_RST)};
      n_total++;
      if (got !== exp_v) $display("FAIL abort i=%0d got=%h expected=%h", i, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int e, n, bl, tot, presses;
    logic m;
    do_reset();
    for (int it = 0; it < 6; it++) begin
      presses = $urandom_range(0, 30);
      for (int i = 0; i < presses; i++) begin
        press(1'($urandom), 1'($urandom));
        n_total++;
        if (EX_time !== EXP_W'(ex_model)) $display("FAIL random_adj it=%0d got=%0d expected=%0d", it, EX_time, ex_model);
        else n_pass++;
      end
      m  = 1'($urandom);
      bl = $urandom_range(0, (1 << BURST_W) - 1);
      n  = (m && bl != 0) ? bl : 1;
      e  = ex_model;
      tot = frame_total(e, n);
      Mode = m;
      Burst_len = BURST_W'(bl);
      Init = 1'b1;
      tick();
      Init = 1'b0;
      for (int t = 0; t <= tot + 1; t++) begin
        if (t > 0) tick();
        exp_v = model(t, e, n, ex_model);
        n_total++;
        if (got !== exp_v) $display("FAIL random it=%0d t=%0d got=%h expected=%h", it, t, got, exp_v);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_exposure();
    test_single();
    test_burst(3, "burst3");
    test_burst(0, "burst0");
    test_ignore_busy();
    test_back_to_back();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/camera_ctrl_param.md
# camera_ctrl_param

Parametrised successor to the pixel-array capture controller. It owns the exposure-time register with saturating increase/decrease and sequences erase, exposure and row-by-row readout across a configurable number of rows. It also supports a burst mode that captures several frames back-to-back from one Init request. It drives the pixel array strobes (Erase, Expose, per-row NRE, ADC) directly and reports Busy/Done to the surrounding system.

## Interface
- ROWS, 2: number of pixel rows read out per frame (≥1)
- ADC_CYCLES, 2: cycles ADC is held high per row (≥1)
- EXP_W, 5: exposure register width
- EXP_MIN, 2 / EXP_MAX, 30 / EXP_RST, 15: exposure bounds and reset value; 1 ≤ EXP_MIN ≤ EXP_RST ≤ EXP_MAX < 2^EXP_W
- BURST_W, 4: width of burst length input

- Clk  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-low (Reset=0 resets at next Clk edge)
- Init  in  1  capture request, level-sampled in IDLE
- Exp_increase  in  1  +1 exposure per cycle held
- Exp_decrease  in  1  −1 exposure per cycle held
- Mode  in  1  0 = single frame, 1 = burst
- Burst_len  in  BURST_W  frames per burst; 0 treated as 1
- NRE  out  ROWS  active-low row read enables, bit k = row k
- ADC  out  1  ADC convert strobe
- Expose  out  1  exposure window
- Erase  out  1  pixel erase
- Busy  out  1  capture in progress
- Done  out  1  one-cycle pulse at end of capture
- EX_time  out  EXP_W  current exposure setting (cycles)

## Operation
- All outputs registered. Reset values: NRE all 1, ADC 0, Expose 0, Erase 1, Busy 0, Done 0, EX_time EXP_RST, state IDLE.
- Reset=0 mid-capture aborts it. The block returns to reset values at that edge, and no Done is issued.
- States: IDLE, EXPOSE, READ, ERASE.
- IDLE: Erase=1, Busy=0.
  - EX_time adjusts each cycle: increase-only gives +1, saturating at EXP_MAX; decrease-only gives −1, saturating at EXP_MIN; both or neither gives no change.
  - Init=1 latches EX_time into the exposure counter and latches the frame count (Mode=0 → 1; Mode=1 → Burst_len, 0→1), then enters EXPOSE.
- EXPOSE: Expose=1, Erase=0, Busy=1 for exactly the latched exposure count, then enters READ with row index 0.
- READ: each row lasts ADC_CYCLES+2 cycles, with NRE[row]=0 for the whole window.
  - ADC=0 in the first and last cycle of the window and ADC=1 in the middle ADC_CYCLES cycles.
  - Rows follow each other with no gap, in ascending order.
  - Only one NRE bit is low at any time.
- After the last row:
  - Frames remaining > 1 → ERASE for 1 cycle (Erase=1, Busy=1, frame count −1), then EXPOSE with the same latched exposure.
  - Otherwise → IDLE with Done=1 for one cycle.
- While Busy: Init, Exp_increase, Exp_decrease, Mode and Burst_len are ignored. EX_time is frozen.
- Init still high in the Done cycle starts a new capture at the next edge.

## Timing
- Init sampled at edge e0 → Expose=1 from e0 to e0+E, where E is the latched EX_time.
- Row k window: from e0+E+k·(ADC_CYCLES+2), lasting ADC_CYCLES+2 cycles.
- Frame length F = E + ROWS·(ADC_CYCLES+2).
- Single frame: Done=1, Busy=0, Erase=1 in the cycle starting at e0+F.
- Burst of N frames: frame j starts at e0+j·(F+1). Done is at e0+N·F+(N−1).
- EX_time updates are visible one cycle after the button is sampled.

## Test plan
- Defaults, EX_time=15, Mode=0, one-cycle Init at e0 → Expose high e0–e15; NRE[0] low e15–e19 with ADC high e16–e18; NRE[1] low e19–e23 with ADC high e20–e22; Done pulse at e23, Busy low from e23.
- Hold Exp_increase 20 cycles from reset → EX_time reaches 30 and stays. Then hold Exp_decrease 40 cycles → EX_time reaches 2 and stays. Both buttons high → EX_time unchanged.
- Mode=1, Burst_len=3, EX_time=2 → three 2-cycle Expose windows, each followed by 8 readout cycles. A 1-cycle Erase separates frames. A single Done at e0+32.
- Mode=1, Burst_len=0 → exactly one frame, Done at e0+F.
- Exp_increase and Init toggled during READ → EX_time unchanged, no restart, one Done only.
- Reset=0 during row 1 → next edge: NRE all 1, ADC 0, Expose 0, Erase 1, Busy 0, EX_time=15, no Done pulse.
